seq_det_sched: RTL
==================

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the number of consecutive stall cycles in RUN after which the open word aborts (legal range 2..255).
REQ-002 Ports SHALL be (name direction width meaning):
  i_w_clk  in  1  single clock, rising edge
  i_w_reset_n  in  1  asynchronous active-low reset
  i_w_valid0  in  1  channel 0 char valid
  i_w_char0  in  1  channel 0 char: 0='a', 1='b'
  i_w_last0  in  1  channel 0 char is last of word
  o_w_ready0  out  1  channel 0 char accepted when valid&ready
  i_w_valid1 / i_w_char1 / i_w_last1 / o_w_ready1  same for channel 1
  o_w_res_valid  out  1  one-cycle result strobe
  o_w_res_ch  out  1  channel the result belongs to
  o_w_res_found  out  1  word contained 'b' followed later by 'a'
  o_w_res_abort  out  1  word ended by timeout, not by last
  o_w_busy  out  1  state != IDLE
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 Control FSM SHALL have states IDLE, RUN, DONE.
REQ-005 IDLE: if any valid is high, the block SHALL latch the grant and go to RUN next edge; both valid -> grant the round-robin pointer channel; one valid -> that channel.
REQ-006 RUN: o_w_readyN SHALL be 1 only for the granted channel and only in RUN; the ungranted channel's ready SHALL stay 0.
REQ-007 Entering RUN SHALL clear the detector to INIT and the stall counter to 0.
REQ-008 Detector SHALL step on each accepted char only: INIT -'b'-> B, INIT -'a'-> INIT, B -'a'-> BA, B -'b'-> B, BA sticky.
REQ-009 Accepted char with last=1 SHALL move RUN -> DONE; found SHALL include that char's detector step.
REQ-010 Stall counter SHALL increment each RUN cycle with no accept and clear on accept; no accept while counter==TIMEOUT-1 SHALL move RUN -> DONE with abort=1.
REQ-011 Accept and timeout in the same cycle: accept SHALL win (counter clears, no abort).
REQ-012 DONE SHALL last exactly one cycle: res_valid=1, res_ch=grant, res_found=(detector==BA), res_abort per REQ-010; then IDLE.
REQ-013 Result latency SHALL be 1 cycle after the accepting edge of the last char.
REQ-014 On leaving DONE the round-robin pointer SHALL become the channel not just served.
REQ-015 res_ch/res_found/res_abort SHALL be 0 when res_valid=0.
REQ-016 Empty word (first accepted char has last=1) SHALL be legal and report found per that char (always 0).

Reset
REQ-017 Reset low SHALL force immediately: FSM=IDLE, detector=INIT, counter=0, pointer=channel 0, all outputs 0.
REQ-018 Reset mid-word SHALL discard the word with no result strobe; after release both channels re-arbitrate from pointer 0.

Structure
REQ-019 Control-state and detector-state encodings and the 'a'/'b' char codes SHALL live in the shared package seq_det_pkg.
REQ-020 Detector SHALL be sub-module ba_step_det (inputs clk, reset_n, clear, enable, char; output found).

Verification
REQ-021 Ch0 sends b,a,b(last) alone -> ready0 high for 3 accepts, res_valid one cycle later with ch=0, found=1, abort=0.
REQ-022 Both valid from reset, ch0 "a,b(last)", ch1 "b,a(last)" -> ch0 served first (found=0), then ch1 (found=1); ready1=0 throughout ch0's word.
REQ-023 TIMEOUT=4, ch1 sends 'b' then drops valid -> abort result after 4 stall cycles with ch=1, found=0, abort=1.
REQ-024 TIMEOUT=4, char accepted on the 4th stall cycle -> no abort, word continues, counter back to 0.
REQ-025 Reset_n low mid-word after "b" -> outputs 0 same cycle, no res_valid, next word "a(last)" reports found=0.
REQ-026 Back-to-back words on both channels, 4 words -> grants alternate 0,1,0,1, one res_valid per word.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared encodings for the two-channel "b then a" word detector and its scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DET_INIT = 2'd0,
    DET_B    = 2'd1,
    DET_BA   = 2'd2
  } det_state_e;

  localparam logic CHAR_A = 1'b0;
  localparam logic CHAR_B = 1'b1;

  localparam int STALL_W = 8;

endpackage

// File: rtl/ba_step_det.sv
// Sticky detector: reports found once a 'b' has been followed later by an 'a'.
module ba_step_det
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic char,
  output logic found
);

  det_state_e state_q;
  det_state_e state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DET_INIT: if (char == CHAR_B) state_d = DET_B;
      DET_B:    if (char == CHAR_A) state_d = DET_BA;
      DET_BA:   state_d = DET_BA;
      default:  state_d = DET_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DET_INIT;
    end else if (clear) begin
      state_q <= DET_INIT;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  assign found = (state_q == DET_BA);

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler that serves one word at a time from two char channels and
// reports whether each word contained 'b' followed later by 'a', with a stall timeout.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_w_clk,
  input  logic i_w_reset_n,
  input  logic i_w_valid0,
  input  logic i_w_char0,
  input  logic i_w_last0,
  output logic o_w_ready0,
  input  logic i_w_valid1,
  input  logic i_w_char1,
  input  logic i_w_last1,
  output logic o_w_ready1,
  output logic o_w_res_valid,
  output logic o_w_res_ch,
  output logic o_w_res_found,
  output logic o_w_res_abort,
  output logic o_w_busy
);

  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  ctrl_state_e        state_q;
  logic               grant_q;
  logic               rr_q;
  logic               abort_q;
  logic [STALL_W-1:0] stall_q;

  logic grant_d;
  logic sel_valid;
  logic sel_char;
  logic sel_last;
  logic accept;
  logic det_found;

  // Pointer breaks ties only when both channels are asking.
  assign grant_d   = (i_w_valid0 && i_w_valid1) ? rr_q : i_w_valid1;
  assign sel_valid = grant_q ? i_w_valid1 : i_w_valid0;
  assign sel_char  = grant_q ? i_w_char1  : i_w_char0;
  assign sel_last  = grant_q ? i_w_last1  : i_w_last0;
  assign accept    = (state_q == ST_RUN) && sel_valid;

  always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
    if (!i_w_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      abort_q <= 1'b0;
      stall_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          stall_q <= '0;
          if (i_w_valid0 || i_w_valid1) begin
            grant_q <= grant_d;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // An accept on the final stall cycle still wins over the timeout.
          if (accept) begin
            stall_q <= '0;
            if (sel_last) state_q <= ST_DONE;
          end else if (stall_q == STALL_LAST) begin
            abort_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        ST_DONE: begin
          rr_q    <= ~grant_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Held in INIT while idle so every word starts from a clean detector.
  ba_step_det u_det (
    .clk     (i_w_clk),
    .reset_n (i_w_reset_n),
    .clear   (state_q == ST_IDLE),
    .enable  (accept),
    .char    (sel_char),
    .found   (det_found)
  );

  assign o_w_ready0    = (state_q == ST_RUN) && !grant_q;
  assign o_w_ready1    = (state_q == ST_RUN) &&  grant_q;
  assign o_w_res_valid = (state_q == ST_DONE);
  assign o_w_res_ch    = (state_q == ST_DONE) && grant_q;
  assign o_w_res_found = (state_q == ST_DONE) && det_found;
  assign o_w_res_abort = (state_q == ST_DONE) && abort_q;
  assign o_w_busy      = (state_q != ST_IDLE);

endmodule
